// File: rtl/audio_nios_hex_ctrl.sv
// audio_nios_hex_ctrl: Avalon-MM seven-segment controller with hex decode, per-digit enable and blink
module audio_nios_hex_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [7*NUM_DIGITS-1:0]   out_port
);
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [16*7-1:0] SEG_LUT = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                         7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  logic [4*NUM_DIGITS-1:0] data_r;
  logic [NUM_DIGITS-1:0]   en_r;
  logic [NUM_DIGITS-1:0]   blink_r;
  logic                    gen_r;
  logic                    phase;
  logic [CW-1:0]           cnt;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    wr;
  logic                    restart;
  assign wr      = chipselect & ~write_n;
  assign restart = wr && address == 2'd3 && writedata[2];
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    logic vis;
    assign vis = gen_r & en_r[d] & ~(blink_r[d] & phase);
    assign seg_next[7*d +: 7] = vis ? SEG_LUT[7*data_r[4*d +: 4] +: 7] : 7'h7F;
  end
  always_comb
    readdata = address == 2'd0 ? 32'(data_r) :
               address == 2'd1 ? 32'(en_r) :
               address == 2'd2 ? 32'(blink_r) : {30'b0, phase, gen_r};
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r   <= '0;
      en_r     <= '1;
      blink_r  <= '0;
      gen_r    <= 1'b1;
      phase    <= 1'b0;
      cnt      <= '0;
      out_port <= '1;
    end else begin
      if (wr && address == 2'd0) data_r  <= writedata[4*NUM_DIGITS-1:0];
      if (wr && address == 2'd1) en_r    <= writedata[NUM_DIGITS-1:0];
      if (wr && address == 2'd2) blink_r <= writedata[NUM_DIGITS-1:0];
      if (wr && address == 2'd3) gen_r   <= writedata[0];
      // restart wins over a coincident terminal count
      if (restart) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else if (cnt == CW'(BLINK_DIV - 1)) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CW'(1);
      end
      out_port <= seg_next;
    end
  end
endmodule

// File: doc/audio_nios_hex_ctrl.md
# audio_nios_hex_ctrl

Parametrised Avalon-MM seven-segment display controller for the audio Nios II system, successor to the fixed-width hex PIO. Software writes one 4-bit nibble per digit, and the block performs the hex-to-segment decode in hardware. It also provides per-digit enable and per-digit blink driven by an internal prescaler. Output drives the board's active-low HEX segment pins directly.

## Interface
Parameters:
- NUM_DIGITS, 6, number of digits driven (legal 1..8)
- BLINK_DIV, 25000000, blink half-period in clk cycles (legal >= 2)

Ports:
- clk  input  1  system clock; the only clock
- reset  input  1  synchronous, active-high reset
- address  input  2  register select
- chipselect  input  1  Avalon slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data, combinational from address, zero wait states
- out_port  output  7*NUM_DIGITS  segments; digit d on [7d+6:7d], bit 0 = seg a … bit 6 = seg g, 0 = lit

## Operation
- A write occurs when chipselect=1 and write_n=0. Writedata bits above each register's width are ignored. Reading unused bits returns 0.
- Addr 0, DATA [4N-1:0]: nibble d at [4d+3:4d]. Reset value is 0.
- Addr 1, ENABLE [N-1:0]: 1 = digit shown, 0 = digit blanked. Reset value is all ones.
- Addr 2, BLINK [N-1:0]: 1 = digit blinks. Reset value is 0.
- Addr 3, CONTROL:
  - bit0 GLOBAL_EN (R/W, reset 1): 0 blanks all digits.
  - bit1 PHASE (read-only): current blink phase.
  - bit2 RESTART (write-1, self-clearing, reads 0).
- Blink prescaler:
  - Counter runs 0..BLINK_DIV-1. At the terminal count it wraps to 0 and toggles PHASE.
  - The counter runs continuously, independent of the BLINK register.
  - Writing RESTART=1 forces counter=0 and PHASE=0 on that edge. RESTART takes priority over a simultaneous terminal count.
- Digit d is visible iff GLOBAL_EN & ENABLE[d] & ~(BLINK[d] & PHASE).
  - A visible digit outputs decode(nibble d).
  - A non-visible digit outputs 7'h7F.
- Decode table (active-low, 0..F): 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E (hex).

## Timing
- All state registers on posedge clk.
- Register write: the written value is visible on readdata from the cycle after the write edge.
- out_port is registered and derived from the current register and PHASE values. It changes one cycle after the register or PHASE update, so write-to-segment latency is 2 clk edges.
- Reset (sync, any time, including mid-blink):
  - On the first edge with reset=1, all registers take their reset values, counter=0 and PHASE=0.
  - out_port=all 7'h7F while reset is held.
  - The first edge after reset deasserts loads decode(0)=7'h40 on every digit.
- readdata is valid in the same cycle as address and chipselect, with no read side effects. Reading addr 3 returns {29'b0, 0, PHASE, GLOBAL_EN}.
- PHASE toggles on the edge where counter==BLINK_DIV-1. A blinking digit therefore spends BLINK_DIV cycles on and BLINK_DIV cycles off, with out_port lagging PHASE by 1 cycle.
- A write to CONTROL with RESTART=1 also updates GLOBAL_EN from writedata bit0 in the same cycle.

## Test plan
- Reset/decode:
  - Stimulus: hold reset 3 cycles, release. Check out_port=all 7F during reset and all 40 one edge after release.
  - Stimulus: write DATA=32'h00FEDCBA (N=6). Check that 2 edges later digits 0..5 = 08,03,46,21,06,0E, and that readback of addr 0 returns 00FEDCBA.
- Enable/global: write ENABLE=6'b101010 → digits 1,3,5 decoded, 0,2,4 = 7F. Then write CONTROL=0 → all 7F, and addr 3 reads 0 (PHASE permitting).
- Blink (BLINK_DIV=4): write BLINK=1 → digit 0 alternates 4 cycles decoded / 4 cycles 7F, other digits steady. Check PHASE readback toggles every 4 cycles.
- Restart collision: issue a RESTART write on the exact cycle counter==BLINK_DIV-1 → PHASE=0, counter=0 after the edge, with no toggle.
- Mid-operation reset: assert reset while PHASE=1 with BLINK set → PHASE=0, BLINK=0, DATA=0, out_port=7F. After release, all digits show 40 with no blinking.
- Width rules: write 32'hFFFFFFFF to ENABLE with N=6 → addr 1 reads 0000003F. Write to addr 0 with chipselect=0 → no change.
